// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencers: FSM encoding, operand widths
// and the writeback packet layout.
package multdiv_pkg;

    localparam int OPA_W              = 32;
    localparam int OPB_W              = 16;
    localparam int RESULT_W           = 32;
    localparam int TIMEOUT_CYCLES_DEF = 15;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [RESULT_W-1:0] result;
        logic                exception;
        logic                timeout;
    } wb_pkt_t;

endpackage

// File: rtl/multdiv_timeout_counter.sv
// Clearable saturating up-counter; hit_o flags the increment that reaches LIMIT.
// Clear wins over enable; no backpressure.
module multdiv_timeout_counter #(
    parameter int LIMIT = 15,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CNT_W'(LIMIT))) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    assign hit_o = en_i && !clr_i && (count_q == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multdiv_mult_ctrl.sv
// Issue/writeback sequencer around the iterative multiplier: accept -> clear -> run -> hold
// packet until wb_ack. Nominal accept-to-wb_valid latency 10 cycles; stall held while busy.
module multdiv_mult_ctrl
    import multdiv_pkg::*;
#(
    parameter int TAG_W          = 5,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                ctrl_MULT_req,
    input  logic [OPA_W-1:0]    data_operandA,
    input  logic [OPB_W-1:0]    data_operandB,
    input  logic [TAG_W-1:0]    data_tag,
    output logic [OPA_W-1:0]    mult_operandA,
    output logic [OPB_W-1:0]    mult_operandB,
    output logic                mult_ctrl_MULT,
    input  logic [RESULT_W-1:0] mult_result,
    input  logic                mult_exception,
    input  logic                mult_inputRDY,
    input  logic                mult_resultRDY,
    output logic                stall,
    output logic                wb_valid,
    output logic [RESULT_W-1:0] wb_result,
    output logic [TAG_W-1:0]    wb_tag,
    output logic                wb_exception,
    output logic                wb_timeout,
    input  logic                wb_ack
);

    logic [1:0]       state_q, state_d;
    logic [OPA_W-1:0] opa_q;
    logic [OPB_W-1:0] opb_q;
    logic [TAG_W-1:0] tag_q, wb_tag_q;
    wb_pkt_t          pkt_q, pkt_d;
    logic             accept, capture, cnt_en, cnt_hit;

    assign accept = (state_q == ST_IDLE) && ctrl_MULT_req;

    multdiv_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i  (clock),
        .rst_ni (resetn),
        .clr_i  (accept),
        .en_i   (cnt_en),
        .hit_o  (cnt_hit)
    );

    // The multiplier self-clears after flagging an exception, so it is captured on the spot.
    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        capture = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_MULT_req) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (mult_inputRDY) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_hit) begin
                        state_d = ST_DONE;
                        capture = 1'b1;
                        pkt_d   = '{result: '0, exception: 1'b1, timeout: 1'b1};
                    end
                end
            end
            ST_RUN: begin
                cnt_en = 1'b1;
                if (mult_exception) begin
                    state_d = ST_DONE;
                    capture = 1'b1;
                    pkt_d   = '{result: '0, exception: 1'b1, timeout: 1'b0};
                end else if (mult_resultRDY) begin
                    state_d = ST_DONE;
                    capture = 1'b1;
                    pkt_d   = '{result: mult_result, exception: 1'b0, timeout: 1'b0};
                end else if (cnt_hit) begin
                    state_d = ST_DONE;
                    capture = 1'b1;
                    pkt_d   = '{result: '0, exception: 1'b1, timeout: 1'b1};
                end
            end
            ST_DONE: begin
                if (wb_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            tag_q    <= '0;
            wb_tag_q <= '0;
            pkt_q    <= '0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            if (accept) begin
                opa_q <= data_operandA;
                opb_q <= data_operandB;
                tag_q <= data_tag;
            end
            if (capture) wb_tag_q <= tag_q;
        end
    end

    assign mult_operandA  = opa_q;
    assign mult_operandB  = opb_q;
    assign mult_ctrl_MULT = (state_q == ST_RUN);
    assign stall          = (state_q != ST_IDLE);
    assign wb_valid       = (state_q == ST_DONE);
    assign wb_result      = pkt_q.result;
    assign wb_exception   = pkt_q.exception;
    assign wb_timeout     = pkt_q.timeout;
    assign wb_tag         = wb_tag_q;

endmodule

// File: tb/tb_multdiv_mult_ctrl.sv
// Bench for multdiv_mult_ctrl with a behavioural iterative-multiplier stub
// (hang and stuck-counter modes) and a cycle-accurate outcome model.
module tb_multdiv_mult_ctrl;

    localparam int TO = 15;

    logic        clock = 1'b0;
    logic        resetn;
    logic        ctrl_MULT_req;
    logic [31:0] data_operandA;
    logic [15:0] data_operandB;
    logic [4:0]  data_tag;
    logic [31:0] mult_operandA;
    logic [15:0] mult_operandB;
    logic        mult_ctrl_MULT;
    logic [31:0] mult_result;
    logic        mult_exception;
    logic        mult_inputRDY;
    logic        mult_resultRDY;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_result;
    logic [4:0]  wb_tag;
    logic        wb_exception;
    logic        wb_timeout;
    logic        wb_ack;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    multdiv_mult_ctrl #(
        .TAG_W          (5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .ctrl_MULT_req  (ctrl_MULT_req),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_tag       (data_tag),
        .mult_operandA  (mult_operandA),
        .mult_operandB  (mult_operandB),
        .mult_ctrl_MULT (mult_ctrl_MULT),
        .mult_result    (mult_result),
        .mult_exception (mult_exception),
        .mult_inputRDY  (mult_inputRDY),
        .mult_resultRDY (mult_resultRDY),
        .stall          (stall),
        .wb_valid       (wb_valid),
        .wb_result      (wb_result),
        .wb_tag         (wb_tag),
        .wb_exception   (wb_exception),
        .wb_timeout     (wb_timeout),
        .wb_ack         (wb_ack)
    );

    // Multiplier stub: counter cleared while enable is low, result at count 7.
    logic [2:0] mcnt;
    bit         stub_hang, stub_stuck;
    longint     prod_s;
    logic       ovf, fire;

    always @(posedge clock or negedge resetn) begin
        if (!resetn)              mcnt <= 3'd0;
        else if (!mult_ctrl_MULT) mcnt <= 3'd0;
        else                      mcnt <= mcnt + 3'd1;
    end

    always_comb begin
        prod_s = longint'($signed(mult_operandA)) * longint'($signed(mult_operandB));
        ovf    = (prod_s != longint'($signed(prod_s[31:0])));
        fire   = mult_ctrl_MULT && (mcnt == 3'd7) && !stub_hang;
    end

    assign mult_inputRDY  = (mcnt == 3'd0) && !stub_stuck;
    assign mult_resultRDY = fire;
    assign mult_exception = fire && ovf;
    assign mult_result    = fire ? prod_s[31:0] : 32'hDEADBEEF;

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic [4:0]  tag;
        bit          hang;
        bit          stuck;
        int          ack_delay;
        int          inject;
        logic [31:0] exp_result;
        bit          exp_exc;
        bit          exp_to;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Outcome from the arithmetic rules: signed 32x16 product, overflow if it leaves 32 bits.
    function automatic vec_t model(input vec_t v);
        vec_t   r = v;
        longint p = longint'($signed(v.a)) * longint'($signed(v.b));
        if (v.stuck) begin
            r.exp_result = 32'd0; r.exp_exc = 1'b1; r.exp_to = 1'b1; r.exp_lat = TO + 1;
        end else if (v.hang) begin
            r.exp_result = 32'd0; r.exp_exc = 1'b1; r.exp_to = 1'b1; r.exp_lat = TO + 2;
        end else if (p > 64'sd2147483647 || p < -64'sd2147483648) begin
            r.exp_result = 32'd0; r.exp_exc = 1'b1; r.exp_to = 1'b0; r.exp_lat = 10;
        end else begin
            r.exp_result = p[31:0]; r.exp_exc = 1'b0; r.exp_to = 1'b0; r.exp_lat = 10;
        end
        return r;
    endfunction

    task automatic check_zero(input string pfx);
        check({pfx, "_opA"},   64'(mult_operandA),  64'd0);
        check({pfx, "_opB"},   64'(mult_operandB),  64'd0);
        check({pfx, "_ctrl"},  64'(mult_ctrl_MULT), 64'd0);
        check({pfx, "_stall"}, 64'(stall),          64'd0);
        check({pfx, "_valid"}, 64'(wb_valid),       64'd0);
        check({pfx, "_res"},   64'(wb_result),      64'd0);
        check({pfx, "_tag"},   64'(wb_tag),         64'd0);
        check({pfx, "_exc"},   64'(wb_exception),   64'd0);
        check({pfx, "_to"},    64'(wb_timeout),     64'd0);
    endtask

    task automatic do_op(input vec_t v);
        int          n;
        logic [31:0] held;
        stub_hang  = v.hang;
        stub_stuck = v.stuck;
        wb_ack     = (v.ack_delay == 0);
        @(negedge clock);
        ctrl_MULT_req = 1'b1;
        data_operandA = v.a;
        data_operandB = v.b;
        data_tag      = v.tag;
        @(negedge clock);
        ctrl_MULT_req = 1'b0;
        data_operandA = $urandom;
        data_operandB = 16'($urandom);
        data_tag      = 5'($urandom);
        n = 1;
        while (!wb_valid && n < 40) begin
            check("stall_busy", 64'(stall), 64'd1);
            if (n == 1) check("ctrl_clear", 64'(mult_ctrl_MULT), 64'd0);
            if (n == 2 && !v.stuck) check("ctrl_run", 64'(mult_ctrl_MULT), 64'd1);
            if (v.inject != 0 && n == v.inject) begin
                ctrl_MULT_req = 1'b1;
                data_operandA = 32'd7;
                data_operandB = 16'd7;
                data_tag      = 5'd3;
            end
            if (v.inject != 0 && n == v.inject + 1) ctrl_MULT_req = 1'b0;
            @(negedge clock);
            n++;
        end
        ctrl_MULT_req = 1'b0;
        check("latency",    64'(n),             64'(v.exp_lat));
        check("wb_result",  64'(wb_result),     64'(v.exp_result));
        check("wb_tag",     64'(wb_tag),        64'(v.tag));
        check("wb_exc",     64'(wb_exception),  64'(v.exp_exc));
        check("wb_timeout", 64'(wb_timeout),    64'(v.exp_to));
        check("stall_done", 64'(stall),         64'd1);
        check("ctrl_done",  64'(mult_ctrl_MULT), 64'd0);
        check("opA_held",   64'(mult_operandA), 64'(v.a));
        check("opB_held",   64'(mult_operandB), 64'(v.b));
        held = wb_result;
        if (v.ack_delay == 0) begin
            @(negedge clock);
        end else begin
            for (int i = 0; i < v.ack_delay; i++) begin
                @(negedge clock);
                check("hold_valid", 64'(wb_valid),  64'd1);
                check("hold_res",   64'(wb_result), 64'(held));
                check("hold_stall", 64'(stall),     64'd1);
            end
            wb_ack = 1'b1;
            @(negedge clock);
        end
        wb_ack = 1'b0;
        check("ack_valid_clr", 64'(wb_valid), 64'd0);
        check("ack_idle",      64'(stall),    64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int   seen;
        vec_t v;
        resetn        = 1'b0;
        ctrl_MULT_req = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 16'd0;
        data_tag      = 5'd0;
        wb_ack        = 1'b0;
        stub_hang     = 1'b0;
        stub_stuck    = 1'b0;
        repeat (2) @(negedge clock);
        check_zero("reset");
        resetn = 1'b1;
        @(negedge clock);

        //          a              b         tag    hang  stuck ackd inj  result         exc   to    lat
        vecs[0] = '{32'd1000,      16'd25,    5'd5,  1'b0, 1'b0, 0,   0,  32'd25000,     1'b0, 1'b0, 10};
        vecs[1] = '{32'hFFFFFFFD,  16'd7,     5'd9,  1'b0, 1'b0, 5,   0,  32'hFFFFFFEB,  1'b0, 1'b0, 10};
        vecs[2] = '{32'h40000000,  16'h0004,  5'd1,  1'b0, 1'b0, 0,   0,  32'd0,         1'b1, 1'b0, 10};
        vecs[3] = '{32'd123,       16'd456,   5'd17, 1'b1, 1'b0, 1,   0,  32'd0,         1'b1, 1'b1, 17};
        vecs[4] = '{32'd5,         16'd5,     5'd30, 1'b0, 1'b1, 0,   0,  32'd0,         1'b1, 1'b1, 16};
        vecs[5] = '{32'h7FFFFFFF,  16'd1,     5'd31, 1'b0, 1'b0, 2,   0,  32'h7FFFFFFF,  1'b0, 1'b0, 10};
        vecs[6] = '{32'h80000000,  16'hFFFF,  5'd4,  1'b0, 1'b0, 0,   0,  32'd0,         1'b1, 1'b0, 10};
        vecs[7] = '{32'd12,        16'd11,    5'd2,  1'b0, 1'b0, 0,   4,  32'd132,       1'b0, 1'b0, 10};
        vecs[8] = '{32'd7,         16'd7,     5'd3,  1'b0, 1'b0, 0,   0,  32'd49,        1'b0, 1'b0, 10};
        for (int i = 0; i < 9; i++) do_op(vecs[i]);

        // Reset in the middle of RUN: everything drops at once and no packet appears later.
        stub_hang  = 1'b0;
        stub_stuck = 1'b0;
        @(negedge clock);
        ctrl_MULT_req = 1'b1;
        data_operandA = 32'd1000;
        data_operandB = 16'd25;
        data_tag      = 5'd5;
        @(negedge clock);
        ctrl_MULT_req = 1'b0;
        repeat (3) @(negedge clock);
        check("midrun_busy", 64'(mult_ctrl_MULT), 64'd1);
        resetn = 1'b0;
        #1;
        check_zero("midrun_rst");
        @(negedge clock);
        resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (wb_valid || stall) seen++;
        end
        check("post_rst_quiet", 64'(seen), 64'd0);

        for (int i = 0; i < 24; i++) begin
            v.a         = (i % 3 == 0) ? $urandom : $urandom_range(0, 100000);
            v.b         = 16'($urandom);
            v.tag       = 5'($urandom);
            v.hang      = (i % 8 == 5);
            v.stuck     = (i == 10);
            v.ack_delay = $urandom_range(0, 3);
            v.inject    = 0;
            do_op(model(v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
